main_controller: RTL and testbench

MAIN_CONTROLLER -- requirements
Module: main_controller

---
 rtl/main_controller.sv | 204 ++++++++++++++++++++
 tb/tb_main_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/main_controller.sv
// Multi-cycle RISC-V style main controller: Moore FSM that sequences fetch, decode, memory, ALU and jump steps.
// Optional MEM_WAIT_EN adds a mem_ready input that stalls FETCH, MEMREAD and MEMWRITE until memory responds.
module main_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [3:0] state_o,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        JALR_WB  = 4'd12,
        HALT     = 4'd13
    } state_t;

    state_t state, state_next;
    logic   ready;
    logic   op_legal;
    logic   taken;
    logic   pc_update, branch;
    logic   ir_en, reg_en, mem_en, ill_raw;

`ifdef MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt && !zero;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXEC_R;
                    OP_I:              state_next = EXEC_I;
                    OP_BR:             state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    default:           state_next = HALT_ON_ILLEGAL ? HALT : FETCH;
                endcase
            end
            MEMADR:   state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = ready ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = ready ? FETCH : MEMWRITE;
            EXEC_R:   state_next = ALUWB;
            EXEC_I:   state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JAL:      state_next = ALUWB;
            JALR:     state_next = JALR_WB;
            JALR_WB:  state_next = FETCH;
            HALT:     state_next = HALT;
            default:  state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Control decode from the state register; only the FETCH enables look at mem_ready.
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        reg_en     = 1'b0;
        mem_en     = 1'b0;
        ill_raw    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (state)
            FETCH: begin
                ir_en      = ready;
                pc_update  = ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                ill_raw   = !op_legal;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_en     = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_en  = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    reg_en = 1'b1;
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            JALR_WB: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_en     = 1'b1;
            end
            HALT:     ill_raw = 1'b1;
            default:  ;
        endcase
    end

    // Reset masks the enables immediately so a stray state before the first edge cannot write.
    assign pc_write  = !reset && (pc_update || (branch && taken));
    assign ir_write  = !reset && ir_en;
    assign reg_write = !reset && reg_en;
    assign mem_write = !reset && mem_en;
    assign illegal   = !reset && ill_raw;
    assign state_o   = reset ? 4'd0 : state;

endmodule

// File: tb/tb_main_controller.sv
// Directed bench for main_controller: reset, each instruction class, branch conditions, illegal halt, mid-instruction reset.
module tb_main_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       zero = 1'b0, lt = 1'b0;
`ifdef MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state_o;

    int checks = 0;
    int passed = 0;

    main_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .op(op), .funct3(funct3), .zero(zero), .lt(lt),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .state_o(state_o), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if ({state_o, pc_write, ir_write, reg_write, mem_write, illegal} !== 9'b0)
            $display("FAIL reset_t0 got %b exp 0", {state_o, pc_write, ir_write, reg_write, mem_write, illegal});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({state_o, pc_write, ir_write, reg_write, mem_write, illegal} !== 9'b0)
                $display("FAIL reset_hold c%0d got %b exp 0", i, {state_o, pc_write, ir_write, reg_write, mem_write, illegal});
            else passed++;
        end
        reset = 1'b0;
        #1;
        checks++; if ({state_o, ir_write, pc_write, adr_src, alu_src_b, result_src} !== {4'd0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10})
            $display("FAIL first_fetch got st=%0d ir=%b pc=%b b=%b rs=%b", state_o, ir_write, pc_write, alu_src_b, result_src);
        else passed++;
    endtask

    task automatic test_lw;
        int es[6] = '{0, 1, 2, 3, 4, 0};
        op = 7'b0000011;
        for (int i = 0; i < 6; i++) begin
            checks++; if (state_o !== 4'(es[i]) || reg_write !== (es[i] == 4) || mem_write !== 1'b0)
                $display("FAIL lw step%0d got st=%0d rw=%b mw=%b exp st=%0d", i, state_o, reg_write, mem_write, es[i]);
            else passed++;
            if (i == 3) begin
                checks++; if (adr_src !== 1'b1 || result_src !== 2'b00)
                    $display("FAIL lw_memread got adr=%b rs=%b exp 1/00", adr_src, result_src);
                else passed++;
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw;
        op = 7'b0100011;
        tick(); tick(); tick();
        checks++; if (state_o !== 4'd5 || mem_write !== 1'b1 || adr_src !== 1'b1)
            $display("FAIL sw_memwrite got st=%0d mw=%b adr=%b exp 5/1/1", state_o, mem_write, adr_src);
        else passed++;
`ifdef MEM_WAIT_EN
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (state_o !== 4'd5 || mem_write !== 1'b1)
                $display("FAIL sw_wait c%0d got st=%0d mw=%b exp 5/1", i, state_o, mem_write);
            else passed++;
        end
        mem_ready = 1'b1;
`endif
        tick();
        checks++; if (state_o !== 4'd0 || mem_write !== 1'b0)
            $display("FAIL sw_done got st=%0d mw=%b exp 0/0", state_o, mem_write);
        else passed++;
    endtask

    task automatic test_r_type;
        int es[5] = '{0, 1, 6, 8, 0};
        op = 7'b0110011;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state_o !== 4'(es[i]) || reg_write !== (es[i] == 8))
                $display("FAIL r_type step%0d got st=%0d rw=%b exp st=%0d", i, state_o, reg_write, es[i]);
            else passed++;
            if (i == 2) begin
                checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_00_10)
                    $display("FAIL r_exec got %b exp 100010", {alu_src_a, alu_src_b, alu_op});
                else passed++;
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_jal;
        int es[5] = '{0, 1, 10, 8, 0};
        int ep[5] = '{1, 0, 1, 0, 1};
        op = 7'b1101111;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state_o !== 4'(es[i]) || pc_write !== ep[i][0] || reg_write !== (es[i] == 8))
                $display("FAIL jal step%0d got st=%0d pw=%b rw=%b exp st=%0d pw=%0d", i, state_o, pc_write, reg_write, es[i], ep[i]);
            else passed++;
            if (i < 4) tick();
        end
    endtask

    task automatic test_jalr;
        int es[5] = '{0, 1, 11, 12, 0};
        int ep[5] = '{1, 0, 1, 0, 1};
        op = 7'b1100111;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state_o !== 4'(es[i]) || pc_write !== ep[i][0] || reg_write !== (es[i] == 12))
                $display("FAIL jalr step%0d got st=%0d pw=%b rw=%b exp st=%0d pw=%0d", i, state_o, pc_write, reg_write, es[i], ep[i]);
            else passed++;
            if (i < 4) tick();
        end
    endtask

    // Each row: funct3, zero, lt, expected pc_write in BRANCH.
    task automatic test_branch;
        logic [5:0] vec [10] = '{
            {3'b000, 1'b1, 1'b0, 1'b1}, {3'b000, 1'b0, 1'b0, 1'b0},
            {3'b001, 1'b0, 1'b0, 1'b1}, {3'b001, 1'b1, 1'b0, 1'b0},
            {3'b100, 1'b0, 1'b1, 1'b1}, {3'b100, 1'b0, 1'b0, 1'b0},
            {3'b101, 1'b0, 1'b0, 1'b1}, {3'b101, 1'b1, 1'b0, 1'b0},
            {3'b101, 1'b0, 1'b1, 1'b0}, {3'b010, 1'b1, 1'b1, 1'b0}};
        op = 7'b1100011;
        for (int i = 0; i < 10; i++) begin
            {funct3, zero, lt} = vec[i][5:1];
            tick();
            checks++; if (state_o !== 4'd1 || pc_write !== 1'b0)
                $display("FAIL br_decode v%0d got st=%0d pw=%b exp 1/0", i, state_o, pc_write);
            else passed++;
            tick();
            checks++; if (state_o !== 4'd9 || pc_write !== vec[i][0] || alu_op !== 2'b01 || alu_src_a !== 2'b10)
                $display("FAIL br_taken v%0d got st=%0d pw=%b op=%b exp 9/%b/01", i, state_o, pc_write, alu_op, vec[i][0]);
            else passed++;
            tick();
            checks++; if (state_o !== 4'd0)
                $display("FAIL br_return v%0d got st=%0d exp 0", i, state_o);
            else passed++;
        end
        zero = 1'b0; lt = 1'b0; funct3 = 3'b000;
    endtask

    task automatic test_mid_reset;
        op = 7'b0000011;
        tick(); tick(); tick();
        checks++; if (state_o !== 4'd3)
            $display("FAIL mid_reset_pre got st=%0d exp 3", state_o);
        else passed++;
        reset = 1'b1;
        #1;
        checks++; if ({state_o, reg_write, mem_write} !== 6'b0)
            $display("FAIL mid_reset_now got %b exp 0", {state_o, reg_write, mem_write});
        else passed++;
        tick();
        checks++; if ({state_o, reg_write, mem_write} !== 6'b0)
            $display("FAIL mid_reset_edge got %b exp 0", {state_o, reg_write, mem_write});
        else passed++;
        reset = 1'b0;
        #1;
        checks++; if (state_o !== 4'd0 || reg_write !== 1'b0 || ir_write !== 1'b1)
            $display("FAIL mid_reset_release got st=%0d rw=%b ir=%b exp 0/0/1", state_o, reg_write, ir_write);
        else passed++;
    endtask

    task automatic test_illegal;
        op = 7'b1111111;
        tick();
        checks++; if (state_o !== 4'd1 || illegal !== 1'b1)
            $display("FAIL ill_decode got st=%0d ill=%b exp 1/1", state_o, illegal);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (state_o !== 4'd13 || illegal !== 1'b1 || {pc_write, ir_write, reg_write, mem_write} !== 4'b0)
                $display("FAIL ill_halt c%0d got st=%0d ill=%b en=%b exp 13/1/0000", i, state_o, illegal,
                         {pc_write, ir_write, reg_write, mem_write});
            else passed++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (state_o !== 4'd0 || illegal !== 1'b0)
            $display("FAIL ill_reset got st=%0d ill=%b exp 0/0", state_o, illegal);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_r_type();
        test_jal();
        test_jalr();
        test_branch();
        test_mid_reset();
        test_illegal();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
